// File: rtl/word_change_scheduler_pkg.sv
// word_change_scheduler_pkg: shared types, index-width helper and reset values for the change scheduler
package word_change_scheduler_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    function automatic int channel_index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam out_state_e STATE_RESET   = EMPTY;
    localparam logic       PRIMED_RESET  = 1'b0;
    localparam logic       PENDING_RESET = 1'b0;
    localparam logic       OVERRUN_RESET = 1'b0;

endpackage

// File: rtl/word_change_scheduler_if.sv
// word_change_scheduler_if: monitored words in, serialised change events out; master = scheduler, slave = consumer
interface word_change_scheduler_if
    import word_change_scheduler_pkg::*;
#(
    parameter int CHANNEL_COUNT = 4,
    parameter int WORD_WIDTH    = 8
);
    localparam int IW = channel_index_width(CHANNEL_COUNT);

    logic [CHANNEL_COUNT*WORD_WIDTH-1:0] input_words;
    logic [CHANNEL_COUNT-1:0]            enable_mask;
    logic                                event_valid;
    logic                                event_ready;
    logic [IW-1:0]                       event_channel;
    logic [WORD_WIDTH-1:0]               event_word;
    logic [CHANNEL_COUNT-1:0]            pending;
    logic [CHANNEL_COUNT-1:0]            overrun;
    logic                                overrun_clear;

    modport master (
        input  input_words, enable_mask, event_ready, overrun_clear,
        output event_valid, event_channel, event_word, pending, overrun
    );

    modport slave (
        output input_words, enable_mask, event_ready, overrun_clear,
        input  event_valid, event_channel, event_word, pending, overrun
    );

endinterface

// File: rtl/word_change_channel.sv
// word_change_channel: per-word change detector with pending flag, latest-value snapshot and optional overrun (WORD_CHANGE_SCHEDULER_OVERRUN_EN)
module word_change_channel
    import word_change_scheduler_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [WORD_WIDTH-1:0] word,
    input  logic                  enable,
    input  logic                  primed,
    input  logic                  grant,
    input  logic                  overrun_clear,
    output logic                  pending,
    output logic [WORD_WIDTH-1:0] snapshot,
    output logic                  overrun
);
    logic [WORD_WIDTH-1:0] prev_q, prev_d, snapshot_q, snapshot_d;
    logic                  pending_q, pending_d, change;

    // A new change beats a same-cycle grant, so the channel stays pending with the newest word
    always_comb begin
        change     = primed && enable && (word != prev_q);
        prev_d     = word;
        snapshot_d = change ? word : snapshot_q;
        pending_d  = change || (pending_q && !grant && enable);
    end

    // Channel state registers
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            prev_q     <= '0;
            snapshot_q <= '0;
            pending_q  <= PENDING_RESET;
        end else begin
            prev_q     <= prev_d;
            snapshot_q <= snapshot_d;
            pending_q  <= pending_d;
        end
    end

    assign pending  = pending_q;
    assign snapshot = snapshot_q;

`ifdef WORD_CHANGE_SCHEDULER_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky overrun: a change lands on a still-unreported value; setting wins over clearing
    always_comb begin
        overrun_d = (overrun_q && !overrun_clear) || (change && pending_q && !grant);
    end

    // Overrun register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) overrun_q <= OVERRUN_RESET;
        else          overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`else
    logic unused_overrun_clear;

    assign unused_overrun_clear = overrun_clear;
    assign overrun              = 1'b0;
`endif

endmodule

// File: rtl/word_change_scheduler.sv
// word_change_scheduler: round-robin serialiser of per-word change events onto one ready/valid port; overrun tracking under WORD_CHANGE_SCHEDULER_OVERRUN_EN
module word_change_scheduler
    import word_change_scheduler_pkg::*;
#(
    parameter int CHANNEL_COUNT = 4,
    parameter int WORD_WIDTH    = 8
) (
    input logic                      clock,
    input logic                      clear_n,
    word_change_scheduler_if.master  bus
);
    localparam int            IW               = channel_index_width(CHANNEL_COUNT);
    localparam logic [IW-1:0] LAST_GRANT_RESET = IW'(CHANNEL_COUNT - 1);

    out_state_e               state_q, state_d;
    logic                     primed_q, primed_d;
    logic [IW-1:0]            last_grant_q, last_grant_d, channel_q, channel_d, sel, idx;
    logic [WORD_WIDTH-1:0]    word_q, word_d;
    logic [CHANNEL_COUNT-1:0] pending, overrun, grant;
    logic [WORD_WIDTH-1:0]    snapshot [CHANNEL_COUNT];
    logic                     found, load;

    for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_ch
        word_change_channel #(.WORD_WIDTH(WORD_WIDTH)) u_ch (
            .clock         (clock),
            .clear_n       (clear_n),
            .word          (bus.input_words[g*WORD_WIDTH +: WORD_WIDTH]),
            .enable        (bus.enable_mask[g]),
            .primed        (primed_q),
            .grant         (grant[g]),
            .overrun_clear (bus.overrun_clear),
            .pending       (pending[g]),
            .snapshot      (snapshot[g]),
            .overrun       (overrun[g])
        );
    end

    // Round-robin pick: first pending channel strictly after the last grant, wrapping around
    always_comb begin
        found = 1'b0;
        sel   = last_grant_q;
        idx   = last_grant_q;
        for (int k = 1; k <= CHANNEL_COUNT; k++) begin
            idx = IW'((int'(last_grant_q) + k) % CHANNEL_COUNT);
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        load  = found && (state_q == EMPTY || bus.event_ready);
        grant = load ? (CHANNEL_COUNT'(1) << sel) : '0;
    end

    // Output register: load on empty or on handshake, drain to EMPTY when nothing is left
    always_comb begin
        primed_d     = 1'b1;
        state_d      = load ? FULL : (bus.event_ready ? EMPTY : state_q);
        channel_d    = load ? sel : channel_q;
        word_d       = load ? snapshot[sel] : word_q;
        last_grant_d = load ? sel : last_grant_q;
    end

    // Scheduler state and registered event outputs
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= STATE_RESET;
            primed_q     <= PRIMED_RESET;
            channel_q    <= '0;
            word_q       <= '0;
            last_grant_q <= LAST_GRANT_RESET;
        end else begin
            state_q      <= state_d;
            primed_q     <= primed_d;
            channel_q    <= channel_d;
            word_q       <= word_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.event_valid   = (state_q == FULL);
    assign bus.event_channel = channel_q;
    assign bus.event_word    = word_q;
    assign bus.pending       = pending;
    assign bus.overrun       = overrun;

endmodule

// File: tb/tb_word_change_scheduler.sv
// tb_word_change_scheduler: directed and random checks of word_change_scheduler against a reference model
module tb_word_change_scheduler;
    localparam int N = 4;
    localparam int W = 8;

    logic clock = 1'b0;
    logic clear_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    word_change_scheduler_if #(.CHANNEL_COUNT(N), .WORD_WIDTH(W)) bus ();

    word_change_scheduler #(.CHANNEL_COUNT(N), .WORD_WIDTH(W)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] m_prev [N];
    logic [W-1:0] m_snap [N];
    bit           m_pend [N];
    bit           m_ovr  [N];
    bit           m_primed, m_valid;
    int           m_lg, m_ch;
    logic [W-1:0] m_word;

    function automatic logic [W-1:0] word_of(input int i);
        return bus.input_words[i*W +: W];
    endfunction

    task automatic set_word(input int i, input logic [W-1:0] v);
        bus.input_words[i*W +: W] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = '0;
            m_snap[i] = '0;
            m_pend[i] = 0;
            m_ovr[i]  = 0;
        end
        m_primed = 0;
        m_valid  = 0;
        m_lg     = N - 1;
        m_ch     = 0;
        m_word   = '0;
    endtask

    task automatic model_step();
        bit chg [N];
        bit gr  [N];
        bit oldp[N];
        bit fire, found;
        for (int i = 0; i < N; i++) begin
            chg[i]  = m_primed && bus.enable_mask[i] && (word_of(i) != m_prev[i]);
            gr[i]   = 0;
            oldp[i] = m_pend[i];
        end
        fire = m_valid && bus.event_ready;
        if (!m_valid || fire) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_lg + k) % N;
                if (!found && oldp[c]) begin
                    found  = 1;
                    gr[c]  = 1;
                    m_ch   = c;
                    m_word = m_snap[c];
                end
            end
            if (found) m_lg = m_ch;
            m_valid = found;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.overrun_clear) m_ovr[i] = 0;
            if (chg[i] && oldp[i] && !gr[i]) m_ovr[i] = 1;
            m_pend[i] = chg[i] || (oldp[i] && !gr[i] && bus.enable_mask[i]);
            if (chg[i]) m_snap[i] = word_of(i);
            m_prev[i] = word_of(i);
        end
        m_primed = 1;
    endtask

    function automatic logic [N-1:0] exp_pend();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_ovr();
        logic [N-1:0] v;
        v = '0;
`ifdef WORD_CHANGE_SCHEDULER_OVERRUN_EN
        for (int i = 0; i < N; i++) v[i] = m_ovr[i];
`endif
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("valid", 64'(bus.event_valid), 64'(m_valid));
        if (m_valid) begin
            check("channel", 64'(bus.event_channel), 64'(m_ch));
            check("word", 64'(bus.event_word), 64'(m_word));
        end
        check("pending", 64'(bus.pending), 64'(exp_pend()));
        check("overrun", 64'(bus.overrun), 64'(exp_ovr()));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        #1;
        model_reset();
        check("reset_valid", 64'(bus.event_valid), 64'd0);
        check("reset_channel", 64'(bus.event_channel), 64'd0);
        check("reset_word", 64'(bus.event_word), 64'd0);
        check("reset_pending", 64'(bus.pending), 64'd0);
        check("reset_overrun", 64'(bus.overrun), 64'd0);
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    initial begin
        bus.input_words   = 32'h44332211;
        bus.enable_mask   = '1;
        bus.event_ready   = 1'b1;
        bus.overrun_clear = 1'b0;
        do_reset();

        // constant nonzero words after reset never produce events
        cycles(10);
        check("idle_valid", 64'(bus.event_valid), 64'd0);
        check("idle_pending", 64'(bus.pending), 64'd0);

        // all four channels change together: order 0,1,2,3 one per cycle
        for (int i = 0; i < N; i++) set_word(i, 8'hA0 + 8'(i));
        cycle();
        check("all_pending", 64'(bus.pending), 64'hF);
        for (int k = 0; k < N; k++) begin
            cycle();
            check("order_valid", 64'(bus.event_valid), 64'd1);
            check("order_channel", 64'(bus.event_channel), 64'(k));
            check("order_word", 64'(bus.event_word), 64'(8'hA0 + 8'(k)));
        end
        cycle();
        check("order_drained", 64'(bus.event_valid), 64'd0);

        // after last grant 3, ch0 and ch3 together report as 0 then 3
        set_word(0, 8'hB0);
        set_word(3, 8'hB3);
        cycles(2);
        check("rr_first", 64'(bus.event_channel), 64'd0);
        cycle();
        check("rr_second", 64'(bus.event_channel), 64'd3);
        cycle();

        // ch2 0x00 -> 0x5A: event two cycles later
        set_word(2, 8'h00);
        cycles(4);
        set_word(2, 8'h5A);
        cycle();
        check("c1_valid", 64'(bus.event_valid), 64'd0);
        cycle();
        check("c2_valid", 64'(bus.event_valid), 64'd1);
        check("c2_channel", 64'(bus.event_channel), 64'd2);
        check("c2_word", 64'(bus.event_word), 64'h5A);
        cycle();
        check("c2_pending", 64'(bus.pending), 64'd0);

        // stalled output on ch1 with two further changes -> overrun, newest value kept
        bus.event_ready = 1'b0;
        set_word(1, 8'h10);
        cycles(2);
        set_word(1, 8'h11);
        cycle();
        set_word(1, 8'h22);
        cycle();
        check("stall_channel", 64'(bus.event_channel), 64'd1);
        check("stall_word", 64'(bus.event_word), 64'h10);
`ifdef WORD_CHANGE_SCHEDULER_OVERRUN_EN
        check("ovr_set", 64'(bus.overrun), 64'h2);
`else
        check("ovr_off", 64'(bus.overrun), 64'h0);
`endif
        bus.event_ready = 1'b1;
        cycle();
        check("newest_word", 64'(bus.event_word), 64'h22);
        cycle();
        bus.overrun_clear = 1'b1;
        cycle();
        bus.overrun_clear = 1'b0;
        check("ovr_cleared", 64'(bus.overrun), 64'h0);

        // grant and new change on ch3 in the same cycle
        set_word(3, 8'h30);
        cycle();
        set_word(3, 8'h31);
        cycle();
        check("same_word", 64'(bus.event_word), 64'h30);
        check("same_pending", 64'(bus.pending), 64'h8);
        cycle();
        check("same_second", 64'(bus.event_word), 64'h31);
        check("same_overrun", 64'(bus.overrun), 64'h0);
        cycle();

        // random phase against the model
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) set_word(i, W'($urandom_range(0, 7)));
            for (int i = 0; i < N; i++) bus.enable_mask[i] = ($urandom_range(0, 7) != 0);
            bus.event_ready   = ($urandom_range(0, 9) < 7);
            bus.overrun_clear = ($urandom_range(0, 9) == 0);
            cycle();
        end

        // reset with an event in flight drops it; nothing reappears until a word changes
        bus.enable_mask   = '1;
        bus.overrun_clear = 1'b0;
        bus.event_ready   = 1'b0;
        set_word(0, ~word_of(0));
        cycles(3);
        check("pre_reset_valid", 64'(bus.event_valid), 64'd1);
        @(posedge clock);
        #2;
        do_reset();
        cycles(10);
        check("post_reset_idle", 64'(bus.event_valid), 64'd0);
        bus.event_ready = 1'b1;
        set_word(1, ~word_of(1));
        cycles(2);
        check("post_reset_event", 64'(bus.event_channel), 64'd1);
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/word_change_scheduler.md
# word_change_scheduler

Monitors several independent input words for changes and serialises the resulting change events onto one ready/valid output, granting channels round-robin. Each event carries the channel index and the new word value. Sits between per-field status/configuration words and a single downstream consumer, e.g. a register-snapshot logger or interrupt source, that can only take one change report per cycle.

## Interface

- CHANNEL_COUNT, 4, number of monitored words; minimum 2
- WORD_WIDTH, 8, bits per word; minimum 1
- clock  input  1  single clock; all state updates on the rising edge
- clear_n  input  1  asynchronous, active-low reset
- input_words  input  CHANNEL_COUNT*WORD_WIDTH  channel i occupies bits [i*WORD_WIDTH +: WORD_WIDTH]
- enable_mask  input  CHANNEL_COUNT  1 = channel monitored
- event_valid  output  1  event offered
- event_ready  input  1  consumer accepts
- event_channel  output  clog2(CHANNEL_COUNT)  index of reporting channel
- event_word  output  WORD_WIDTH  newest value of that channel at grant time
- pending  output  CHANNEL_COUNT  per-channel unreported change
- overrun  output  CHANNEL_COUNT  sticky: a change occurred while already pending
- overrun_clear  input  1  clears all overrun bits

## Operation

- Per channel: prev register samples the channel word every cycle. change = (word != prev) AND primed AND enable_mask[i].
- primed is 0 out of reset and becomes 1 after the first clock edge. The first post-reset cycle only loads prev and never produces events.
- Change on channel i sets pending[i] and loads snapshot[i] with the current word. If pending[i] is already set, snapshot[i] is overwritten with the newest value, so the older value is lost.
- Output register states: EMPTY (event_valid=0) and FULL (event_valid=1).
- In EMPTY with pending nonzero: pick the first pending channel strictly after last_grant, searching modulo CHANNEL_COUNT. Load event_channel and event_word from snapshot, clear that pending bit, update last_grant, go FULL.
- In FULL: event_channel and event_word stay stable until event_valid AND event_ready. On that handshake:
  - if pending is nonzero, the next grant loads in the same edge and the state stays FULL;
  - otherwise the state goes EMPTY.
- Grant and a new change on the same channel in the same cycle: set wins. pending stays 1 and the snapshot takes the new word. The granted event carries the pre-change snapshot.
- enable_mask[i]=0 clears pending[i] at the next edge. An event already in the output register is not retracted.
- Reset mid-operation: all state returns to reset values immediately. The in-flight event is dropped.

## Timing

- Reset values:
  - event_valid=0, event_channel=0, event_word=0
  - pending=0, overrun=0, prev=0, primed=0
  - last_grant=CHANNEL_COUNT-1, so channel 0 is first priority
- A change present in cycle C sets pending in C+1. event_valid rises in C+2 if the output is EMPTY.
- Throughput: one event per cycle while event_ready=1 and pending is nonzero.
- overrun[i] rises the cycle after a change hits an already-pending channel. When the grant clears pending in that same cycle, this is not an overrun.
- overrun_clear and a new overrun on the same cycle: set wins.

## Configuration

- WORD_CHANGE_SCHEDULER_OVERRUN_EN defined: overrun tracking is implemented as described.
- Not defined: the overrun output is tied to 0, overrun_clear is ignored, and no overrun flops are generated. The port list is unchanged.

## Structure

- Package word_change_scheduler_pkg holds:
  - the output state enum (EMPTY, FULL);
  - a clog2-based CHANNEL_INDEX_WIDTH helper;
  - reset-value constants.
- Sub-module word_change_channel, one instance per channel, holds prev, snapshot, pending, overrun and the change compare. Its inputs are grant and enable, and its outputs are pending and snapshot.
- The top level holds the round-robin search and the output register.

## Test plan

- Reset with input_words nonzero and all channels enabled; hold input_words constant -> event_valid stays 0 indefinitely and pending=0.
- Change ch2 from 0x00 to 0x5A in cycle C, event_ready=1 -> event_valid=1 in C+2 with event_channel=2 and event_word=0x5A; pending=0 afterwards.
- Change ch0..ch3 in the same cycle with event_ready=1 -> four consecutive events in order 0,1,2,3, one per cycle. A further change to ch0 then ch3 (after last_grant=3) -> order 0,3.
- Hold event_ready=0 with ch1 FULL; change ch1 twice (0x11 then 0x22) -> outputs stay stable, overrun[1]=1, and the next event reports 0x22. Pulse overrun_clear -> overrun[1]=0. With the macro undefined -> overrun stays 0.
- Grant on ch3 in the same cycle ch3 changes -> pending[3] stays 1 and a second ch3 event follows with the new value.
- Assert clear_n mid-stream with event_valid=1 -> event_valid=0 immediately. No event appears after release until an input word changes.
